mul_seq_4bit: RTL and testbench

MUL_SEQ_4BIT -- requirements
Module: mul_seq_4bit

---
 rtl/mul_seq_pkg.sv | 12 +
 rtl/mul_seq_4bit_add_nbit.sv | 23 ++
 rtl/mul_seq_4bit.sv | 101 ++++++++++
 tb/tb_mul_seq_4bit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_seq_pkg;

    localparam int unsigned DEF_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq_4bit_add_nbit.sv
// W-bit ripple-carry adder with carry-in and carry-out.
module add_nbit #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[W];

endmodule

// File: rtl/mul_seq_4bit.sv
// Sequential shift-add unsigned multiplier: W add/shift edges, then one commit edge into DONE.
// Optional build macro MUL_SEQ_4BIT_ZERO_SKIP_EN short-circuits zero operands straight to DONE.
module mul_seq_4bit
    import mul_seq_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned CW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] p
);

    if (W < 2 || W > 8 || (1 << CW) <= W) begin : g_bad_param
        $error("mul_seq_4bit: illegal W/CW combination");
    end

    localparam logic [CW-1:0] CntLast = CW'(W);

    mul_state_e     r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_a;
    logic [2*W:0]   r_sr;     // {carry, accumulator, multiplier}
    logic [2*W-1:0] r_p;

    logic [W-1:0]   w_sum;
    logic           w_co;
    logic [2*W:0]   w_step;
    logic [2*W:0]   w_shift;
    logic           w_last;

    add_nbit #(
        .W (W)
    ) u_add (
        .a  (r_a),
        .b  (r_sr[2*W-1:W]),
        .ci (1'b0),
        .s  (w_sum),
        .co (w_co)
    );

    always_comb begin
        w_step  = r_sr;
        if (r_sr[0]) begin
            w_step = {w_co, w_sum, r_sr[W-1:0]};
        end
        w_shift = w_step >> 1;
        w_last  = (r_cnt == CntLast);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_sr    <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_a     <= a;
                        r_sr    <= {1'b0, {W{1'b0}}, b};
                        r_cnt   <= '0;
`ifdef MUL_SEQ_4BIT_ZERO_SKIP_EN
                        // Counter preloaded to the end: next edge commits a zero product.
                        if (a == '0 || b == '0) begin
                            r_cnt <= CntLast;
                            r_sr  <= '0;
                        end
`endif
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_p     <= r_sr[2*W-1:0];
                    end else begin
                        r_sr  <= w_shift;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The commit cycle (counter at its end) is not counted as busy.
    assign busy = (r_state == RUN) && !w_last;
    assign done = (r_state == DONE);
    assign p    = r_p;

endmodule

// File: tb/tb_mul_seq_4bit.sv
// Self-checking bench for mul_seq_4bit against a plain a*b / latency model.
module tb_mul_seq_4bit;

    localparam int W   = 4;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [2*W-1:0] p;

    int n_vec = 0;
    int n_err = 0;

    mul_seq_4bit #(
        .W  (W),
        .CW (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [W-1:0] ia, input logic [W-1:0] ib);
`ifdef MUL_SEQ_4BIT_ZERO_SKIP_EN
        if (ia == 0 || ib == 0) return 1;
`endif
        return LAT;
    endfunction

    function automatic int exp_busy(input logic [W-1:0] ia, input logic [W-1:0] ib);
        return (exp_lat(ia, ib) == 1) ? 0 : W;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or after the budget).
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int lat,
                         output int busy_cycles, output logic p_held);
        logic [2*W-1:0] p0;
        p0    = p;
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        a           = $urandom_range(0, 15);
        b           = $urandom_range(0, 15);
        lat         = 0;
        busy_cycles = 0;
        p_held      = 1'b1;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            if (p !== p0) p_held = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd7;
        b     = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, done, p} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b p=%0d, want 0 0 0", busy, done, p);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_max;
        int lat, bc;
        logic held;
        do_op(4'd15, 4'd15, lat, bc, held);
        n_vec += 4;
        if (p !== 8'hE1) begin
            n_err++;
            $display("FAIL max_product: p=%0d, want 225", p);
        end
        if (lat != LAT) begin
            n_err++;
            $display("FAIL max_latency: got %0d edges, want %0d", lat, LAT);
        end
        if (bc != W) begin
            n_err++;
            $display("FAIL max_busy: busy for %0d cycles, want %0d", bc, W);
        end
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL max_busy_at_done: busy=%b, want 0", busy);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL max_done_pulse: done=%b one cycle later, want 0", done);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        logic held;
        do_op(4'd6, 4'd7, lat, bc, held);
        n_vec += 2;
        if (p !== 8'd42 || lat != LAT) begin
            n_err++;
            $display("FAIL b2b_first: p=%0d lat=%0d, want 42 lat %0d", p, lat, LAT);
        end
        // do_op starts from this DONE cycle; done must drop on the next edge.
        do_op(4'd9, 4'd3, lat, bc, held);
        if (lat != LAT) begin
            n_err++;
            $display("FAIL b2b_second_latency: got %0d, want %0d (0 means done stuck high)",
                     lat, LAT);
        end
        n_vec += 2;
        if (p !== 8'd27) begin
            n_err++;
            $display("FAIL b2b_second_product: p=%0d, want 27", p);
        end
        if (!held) begin
            n_err++;
            $display("FAIL b2b_p_hold: p changed before second done, want 42 held");
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat;
        a     = 4'd5;
        b     = 4'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!done && lat < 20) begin
            if (lat >= 1 && lat <= 3) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_vec += 2;
        if (p !== 8'd15) begin
            n_err++;
            $display("FAIL ignore_product: p=%0d, want 15", p);
        end
        if (lat != LAT) begin
            n_err++;
            $display("FAIL ignore_latency: got %0d, want %0d", lat, LAT);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_err++;
                $display("FAIL ignore_no_extra_op: cycle %0d busy=%b done=%b, want 0 0",
                         i, busy, done);
            end
        end
    endtask

    task automatic test_reset_abort;
        int lat, bc;
        logic held, pulsed;
        a     = 4'd13;
        b     = 4'd11;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, done, p} !== 10'd0) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b p=%0d, want 0 0 0", busy, done, p);
        end
        pulsed = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulsed = 1'b1;
        end
        n_vec++;
        if (pulsed) begin
            n_err++;
            $display("FAIL abort_no_done: done=1 after abort, want 0");
        end
        do_op(4'd12, 4'd10, lat, bc, held);
        n_vec++;
        if (p !== 8'd120 || lat != LAT) begin
            n_err++;
            $display("FAIL abort_restart: p=%0d lat=%0d, want 120 lat %0d", p, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        int lat, bc;
        logic held;
        do_op(4'd0, 4'd9, lat, bc, held);
        n_vec += 3;
        if (p !== 8'd0) begin
            n_err++;
            $display("FAIL zero_product: p=%0d, want 0", p);
        end
        if (lat != exp_lat(4'd0, 4'd9)) begin
            n_err++;
            $display("FAIL zero_latency: got %0d, want %0d", lat, exp_lat(4'd0, 4'd9));
        end
        if (bc != exp_busy(4'd0, 4'd9)) begin
            n_err++;
            $display("FAIL zero_busy: busy for %0d cycles, want %0d", bc,
                     exp_busy(4'd0, 4'd9));
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat, bc;
        logic held;
        logic [W-1:0] ra, rb;
        logic [2*W-1:0] prod;
        for (int i = 0; i < 10; i++) begin
            ra   = W'($urandom_range(0, 15));
            rb   = W'($urandom_range(0, 15));
            prod = (2*W)'(int'(ra) * int'(rb));
            do_op(ra, rb, lat, bc, held);
            n_vec += 3;
            if (p !== prod) begin
                n_err++;
                $display("FAIL rand_product[%0d]: %0d*%0d p=%0d, want %0d", i, ra, rb, p, prod);
            end
            if (lat != exp_lat(ra, rb)) begin
                n_err++;
                $display("FAIL rand_latency[%0d]: got %0d, want %0d", i, lat, exp_lat(ra, rb));
            end
            if (!held) begin
                n_err++;
                $display("FAIL rand_p_hold[%0d]: p changed before done", i);
            end
            if (i % 2 == 1) @(negedge clk);
        end
    endtask

    initial begin
        void'($urandom(32'd2024));
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset;
        test_max;
        test_back_to_back;
        test_ignore_start;
        test_reset_abort;
        test_zero;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
